// File: rtl/ili9341_pkg.sv
// Shared constants and state encoding for the ILI9341 8080 write-bus decoder.
package ili9341_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

  localparam int unsigned ILI_COLS = 320;
  localparam int unsigned ILI_ROWS = 240;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/ili9341_bus_sampler.sv
// Registers every bus line once and detects the wr rising edge while cs is low.
module ili9341_bus_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_cs,
  input  logic       raw_cd,
  input  logic       raw_wr,
  input  logic       raw_rd,
  input  logic       raw_tft_rst,
  input  logic [7:0] raw_data,
  output logic       strobe,
  output logic       cd,
  output logic [7:0] data,
  output logic       tft_rst_n,
  output logic       rd_n
);

  logic       wr_q;
  logic       cs_q;
  logic       cd_q;
  logic [7:0] data_q;
  logic       tft_rst_q;
  logic       rd_q;

  // One register stage on every bus line; strobe lines idle high after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= 1'b1;
      cs_q      <= 1'b1;
      cd_q      <= 1'b0;
      data_q    <= '0;
      tft_rst_q <= 1'b1;
      rd_q      <= 1'b1;
    end else begin
      wr_q      <= raw_wr;
      cs_q      <= raw_cs;
      cd_q      <= raw_cd;
      data_q    <= raw_data;
      tft_rst_q <= raw_tft_rst;
      rd_q      <= raw_rd;
    end
  end

  // Rising wr edge (registered low, live high) with chip select held low.
  always_comb begin
    strobe    = !wr_q && raw_wr && !cs_q;
    cd        = cd_q;
    data      = data_q;
    tft_rst_n = tft_rst_q;
    rd_n      = rd_q;
  end

endmodule

// File: rtl/ili9341_bus_rx.sv
// ILI9341 write-bus decoder: command decode, address windows, x/y walk, pixel assembly.
module ili9341_bus_rx
  import ili9341_pkg::*;
#(
  parameter int unsigned COLS   = ILI_COLS,
  parameter int unsigned ROWS   = ILI_ROWS,
  parameter int unsigned X_BITS = 9,
  parameter int unsigned Y_BITS = 9
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_cs,
  input  logic              in_cd,
  input  logic              in_wr,
  input  logic              in_rd,
  input  logic              in_tft_rst,
  input  logic [7:0]        in_data,
  output logic              cmd_valid,
  output logic [7:0]        cmd_code,
  output logic              pixel_valid,
  output logic [X_BITS-1:0] pixel_x,
  output logic [Y_BITS-1:0] pixel_y,
  output logic [15:0]       pixel_color,
  output logic              frame_done,
  output logic              err_window,
  output logic              err_read
);

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(COLS - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(ROWS - 1);

  logic       strobe;
  logic       cd;
  logic [7:0] data;
  logic       tft_rst_n;
  logic       rd_n;
  logic       sync_rst;

  state_t state, state_next;

  logic [X_BITS-1:0] sc, ec, x;
  logic [Y_BITS-1:0] sp, ep, y;
  logic [2:0]        param_idx;
  logic [23:0]       shadow;
  logic              msb_phase;
  logic [7:0]        msb;
  logic              blocked;
  logic [15:0]       win_start;
  logic [15:0]       win_end;
  logic              win_bad;
  logic              entry_bad;

  ili9341_bus_sampler u_sampler (
    .clk         (in_clk),
    .rst         (in_rst),
    .raw_cs      (in_cs),
    .raw_cd      (in_cd),
    .raw_wr      (in_wr),
    .raw_rd      (in_rd),
    .raw_tft_rst (in_tft_rst),
    .raw_data    (in_data),
    .strobe      (strobe),
    .cd          (cd),
    .data        (data),
    .tft_rst_n   (tft_rst_n),
    .rd_n        (rd_n)
  );

  assign sync_rst = in_rst || !tft_rst_n;

  // Decoder state register.
  always_ff @(posedge in_clk) begin
    if (sync_rst) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next state from command bytes; window validity for the 4th param and RAMWR entry.
  always_comb begin
    state_next = state;
    win_start  = shadow[23:8];
    win_end    = {shadow[7:0], data};
    win_bad    = (win_start > win_end) ||
                 (32'(win_end) >= ((state == ST_CASET) ? COLS : ROWS));
    entry_bad  = (sc > ec) || (sp > ep);
    if (strobe && !cd) begin
      case (data)
        CMD_CASET:   state_next = ST_CASET;
        CMD_PASET:   state_next = ST_PASET;
        CMD_RAMWR:   state_next = ST_RAMWR;
        CMD_RAMWRC:  state_next = ST_RAMWR;
        CMD_SWRESET: state_next = ST_IDLE;
        default:     state_next = ST_IGNORE;
      endcase
    end
  end

  // Window registers, parameter shadowing, x/y walk and registered outputs.
  always_ff @(posedge in_clk) begin
    if (sync_rst) begin
      sc          <= '0;
      ec          <= X_LAST;
      sp          <= '0;
      ep          <= Y_LAST;
      x           <= '0;
      y           <= '0;
      param_idx   <= '0;
      shadow      <= '0;
      msb_phase   <= 1'b1;
      msb         <= '0;
      blocked     <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_color <= '0;
      frame_done  <= 1'b0;
      err_window  <= 1'b0;
      err_read    <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (!rd_n) err_read <= 1'b1;
      if (strobe && !cd) begin
        cmd_valid <= 1'b1;
        cmd_code  <= data;
        param_idx <= '0;
        msb_phase <= 1'b1;
        case (data)
          CMD_RAMWR: begin
            x       <= sc;
            y       <= sp;
            blocked <= entry_bad;
            if (entry_bad) err_window <= 1'b1;
          end
          CMD_RAMWRC: begin
            blocked <= entry_bad;
            if (entry_bad) err_window <= 1'b1;
          end
          CMD_SWRESET: begin
            sc <= '0;
            ec <= X_LAST;
            sp <= '0;
            ep <= Y_LAST;
          end
          default: ;
        endcase
      end else if (strobe && cd) begin
        case (state)
          ST_CASET, ST_PASET: begin
            if (param_idx != 3'd4) begin
              param_idx <= param_idx + 3'd1;
              case (param_idx)
                3'd0: shadow[23:16] <= data;
                3'd1: shadow[15:8]  <= data;
                3'd2: shadow[7:0]   <= data;
                default: begin
                  // Window commits only on the final byte; bad values still load, truncated.
                  if (win_bad) err_window <= 1'b1;
                  if (state == ST_CASET) begin
                    sc <= win_start[X_BITS-1:0];
                    ec <= win_end[X_BITS-1:0];
                  end else begin
                    sp <= win_start[Y_BITS-1:0];
                    ep <= win_end[Y_BITS-1:0];
                  end
                end
              endcase
            end
          end
          ST_RAMWR: begin
            if (!blocked) begin
              if (msb_phase) begin
                msb       <= data;
                msb_phase <= 1'b0;
              end else begin
                msb_phase   <= 1'b1;
                pixel_valid <= 1'b1;
                pixel_x     <= x;
                pixel_y     <= y;
                pixel_color <= {msb, data};
                if (x == ec) begin
                  x <= sc;
                  if (y == ep) begin
                    y          <= sp;
                    frame_done <= 1'b1;
                  end else begin
                    y <= y + Y_BITS'(1);
                  end
                end else begin
                  x <= x + X_BITS'(1);
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ili9341_bus_rx.sv
// Directed, table-driven bench for the ILI9341 write-bus decoder.
module tb_ili9341_bus_rx;

  logic       clk = 1'b0;
  logic       in_rst;
  logic       in_cs;
  logic       in_cd;
  logic       in_wr;
  logic       in_rd;
  logic       in_tft_rst;
  logic [7:0] in_data;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       pixel_valid;
  logic [8:0] pixel_x;
  logic [8:0] pixel_y;
  logic [15:0] pixel_color;
  logic       frame_done;
  logic       err_window;
  logic       err_read;

  always #5 clk = ~clk;

  ili9341_bus_rx #(.COLS(320), .ROWS(240), .X_BITS(9), .Y_BITS(9)) dut (
    .in_clk      (clk),
    .in_rst      (in_rst),
    .in_cs       (in_cs),
    .in_cd       (in_cd),
    .in_wr       (in_wr),
    .in_rd       (in_rd),
    .in_tft_rst  (in_tft_rst),
    .in_data     (in_data),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .pixel_valid (pixel_valid),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_color (pixel_color),
    .frame_done  (frame_done),
    .err_window  (err_window),
    .err_read    (err_read)
  );

  typedef struct {
    logic        cd;
    logic [7:0]  d;
    logic        cv;
    logic        pv;
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] col;
    logic        fd;
  } vec_t;

  vec_t vecs[$];
  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned pix_count = 0;

  // Count every pixel pulse; a pulse wider than one cycle inflates the count.
  always @(negedge clk) if (pixel_valid === 1'b1) pix_count++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after the registered response.
  task automatic wbyte(input logic cd, input logic [7:0] d, input logic cs = 1'b0);
    in_cs = cs; in_cd = cd; in_data = d; in_wr = 1'b0;
    @(negedge clk);
    in_wr = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    in_rst = 1'b1;
    idle(n);
    in_rst = 1'b0;
  endtask

  function automatic void add(input logic cd, input logic [7:0] d, input logic cv, input logic pv,
                              input logic [8:0] x, input logic [8:0] y, input logic [15:0] col,
                              input logic fd);
    vec_t v;
    v.cd = cd; v.d = d; v.cv = cv; v.pv = pv; v.x = x; v.y = y; v.col = col; v.fd = fd;
    vecs.push_back(v);
  endfunction

  function automatic void cmd(input logic [7:0] c);
    add(1'b0, c, 1'b1, 1'b0, '0, '0, '0, 1'b0);
  endfunction

  function automatic void dat(input logic [7:0] d);
    add(1'b1, d, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endfunction

  function automatic void pix(input logic [7:0] m, input logic [7:0] l,
                              input logic [8:0] x, input logic [8:0] y, input logic fd);
    dat(m);
    add(1'b1, l, 1'b0, 1'b1, x, y, {m, l}, fd);
  endfunction

  logic [63:0] outs;
  int unsigned snap;

  initial begin
    logic ok;
    in_rst = 1'b1; in_cs = 1'b1; in_cd = 1'b0; in_wr = 1'b1; in_rd = 1'b1;
    in_tft_rst = 1'b1; in_data = '0;
    idle(3);
    in_rst = 1'b0;
    outs = {cmd_valid, cmd_code, pixel_valid, pixel_x, pixel_y, pixel_color, frame_done,
            err_window, err_read};
    chk("reset_outputs", outs, 64'd0);

    // Sub-window walk, RAMWRC break, unknown command, SWRESET and IDLE data.
    cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0C); dat(8'h55);
    cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
    cmd(8'h2C);
    pix(8'h10, 8'h80, 9'd10, 9'd5, 1'b0);
    pix(8'h11, 8'h81, 9'd11, 9'd5, 1'b0);
    pix(8'h12, 8'h82, 9'd12, 9'd5, 1'b0);
    pix(8'h13, 8'h83, 9'd10, 9'd6, 1'b0);
    pix(8'h14, 8'h84, 9'd11, 9'd6, 1'b0);
    pix(8'h15, 8'h85, 9'd12, 9'd6, 1'b1);
    pix(8'h16, 8'h86, 9'd10, 9'd5, 1'b0);
    cmd(8'h2C);
    pix(8'hA1, 8'hA2, 9'd10, 9'd5, 1'b0);
    dat(8'hB1);
    cmd(8'h3C);
    pix(8'hC1, 8'hC2, 9'd11, 9'd5, 1'b0);
    cmd(8'hB1); dat(8'h00); dat(8'h03);
    cmd(8'h2C);
    pix(8'hD1, 8'hD2, 9'd10, 9'd5, 1'b0);
    cmd(8'h01); dat(8'h77); dat(8'h78);
    cmd(8'h2C);
    pix(8'hE1, 8'hE2, 9'd0, 9'd0, 1'b0);

    snap = pix_count;
    foreach (vecs[i]) begin
      wbyte(vecs[i].cd, vecs[i].d);
      ok = (cmd_valid === vecs[i].cv) && (pixel_valid === vecs[i].pv);
      if (vecs[i].pv)
        ok = ok && (pixel_x === vecs[i].x) && (pixel_y === vecs[i].y) &&
             (pixel_color === vecs[i].col) && (frame_done === vecs[i].fd);
      else
        ok = ok && (frame_done === 1'b0);
      total++;
      if (ok) passed++;
      else $display("FAIL vec[%0d]: got cv=%b pv=%b x=%0d y=%0d col=%h fd=%b expected cv=%b pv=%b x=%0d y=%0d col=%h fd=%b",
                    i, cmd_valid, pixel_valid, pixel_x, pixel_y, pixel_color, frame_done,
                    vecs[i].cv, vecs[i].pv, vecs[i].x, vecs[i].y, vecs[i].col, vecs[i].fd);
    end
    idle(2);
    chk("table_pixel_count", 64'(pix_count - snap), 64'd11);
    chk("table_cmd_code", 64'(cmd_code), 64'h2C);
    chk("table_err_window", 64'(err_window), 64'd0);

    // Frame walk over the bottom-right corner of the panel.
    wbyte(0, 8'h2A); wbyte(1, 8'h01); wbyte(1, 8'h3C); wbyte(1, 8'h01); wbyte(1, 8'h3F);
    wbyte(0, 8'h2B); wbyte(1, 8'h00); wbyte(1, 8'hEC); wbyte(1, 8'h00); wbyte(1, 8'hEF);
    chk("corner_err_window", 64'(err_window), 64'd0);
    wbyte(0, 8'h2C);
    for (int i = 0; i < 17; i++) begin
      int k;
      k = i % 16;
      wbyte(1, 8'hF8);
      wbyte(1, 8'h00);
      chk($sformatf("corner_px%0d", i),
          {pixel_valid, frame_done, pixel_x, pixel_y, pixel_color},
          {1'b1, (k == 15), 9'(316 + k % 4), 9'(236 + k / 4), 16'hF800});
    end

    // Reset in the middle of a pixel pair.
    wbyte(1, 8'hF8);
    do_reset(3);
    outs = {cmd_valid, cmd_code, pixel_valid, pixel_x, pixel_y, pixel_color, frame_done,
            err_window, err_read};
    chk("midframe_reset_outputs", outs, 64'd0);
    wbyte(0, 8'h2C); wbyte(1, 8'h12); wbyte(1, 8'h34);
    chk("after_reset_px", {pixel_valid, pixel_x, pixel_y, pixel_color},
        {1'b1, 9'd0, 9'd0, 16'h1234});

    // Inverted column window blocks RAMWR data.
    wbyte(0, 8'h2A); wbyte(1, 8'h00); wbyte(1, 8'h05); wbyte(1, 8'h00); wbyte(1, 8'h02);
    chk("inverted_err_window", 64'(err_window), 64'd1);
    idle(2);
    snap = pix_count;
    wbyte(0, 8'h2C); wbyte(1, 8'h11); wbyte(1, 8'h22); wbyte(1, 8'h33); wbyte(1, 8'h44);
    idle(2);
    chk("inverted_no_pixels", 64'(pix_count - snap), 64'd0);
    do_reset(2);
    chk("err_window_cleared", 64'(err_window), 64'd0);

    // Column end equal to COLS is out of range.
    wbyte(0, 8'h2A); wbyte(1, 8'h00); wbyte(1, 8'h00); wbyte(1, 8'h01); wbyte(1, 8'h40);
    chk("end_eq_cols_err", 64'(err_window), 64'd1);
    do_reset(2);

    // Read strobe low for one cycle is sticky until reset.
    in_rd = 1'b0;
    idle(1);
    in_rd = 1'b1;
    idle(2);
    chk("err_read_set", 64'(err_read), 64'd1);
    idle(5);
    chk("err_read_sticky", 64'(err_read), 64'd1);
    do_reset(2);
    chk("err_read_cleared", 64'(err_read), 64'd0);

    // Strobes with chip select high are ignored.
    wbyte(0, 8'h2C, 1'b1);
    chk("cs_high_no_cmd", 64'(cmd_valid), 64'd0);
    wbyte(1, 8'hAB); wbyte(1, 8'hCD);
    chk("cs_high_no_pixel", 64'(pixel_valid), 64'd0);

    // Panel reset restores the default window and blocks strobes while low.
    wbyte(0, 8'h2A); wbyte(1, 8'h00); wbyte(1, 8'h0A); wbyte(1, 8'h00); wbyte(1, 8'h0C);
    wbyte(0, 8'h2B); wbyte(1, 8'h00); wbyte(1, 8'h05); wbyte(1, 8'h00); wbyte(1, 8'h06);
    in_tft_rst = 1'b0;
    idle(1);
    wbyte(0, 8'h2C);
    chk("tft_rst_no_cmd", 64'(cmd_valid), 64'd0);
    chk("tft_rst_cmd_code", 64'(cmd_code), 64'd0);
    in_tft_rst = 1'b1;
    idle(2);
    wbyte(0, 8'h2C); wbyte(1, 8'h56); wbyte(1, 8'h78);
    chk("tft_rst_default_px", {pixel_valid, pixel_x, pixel_y, pixel_color},
        {1'b1, 9'd0, 9'd0, 16'h5678});

    idle(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
